// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin write-back arbiter with a credited single-slot output stage
module wb_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 32,
  parameter int IDW     = 2,
  parameter int CREDITS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_data,
  output logic [IDW-1:0]       out_id,
  input  logic                 credit_ret,
  output logic                 credit_err
);

  localparam int            CW       = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

  // Output slot and arbitration state
  logic            slot_full_q, slot_full_d;
  logic [DW-1:0]   slot_data_q, slot_data_d;
  logic [IDW-1:0]  slot_id_q,   slot_id_d;
  logic [IDW-1:0]  rr_ptr_q,    rr_ptr_d;
  logic [CW-1:0]   credit_q,    credit_d;
  logic            credit_err_q, credit_err_d;

  logic            out_hs;
  logic            loadable;
  logic            any_req;
  logic [IDW-1:0]  winner;
  logic            req_hs;

  // Outputs come straight from registers so out_ready/credit_ret never reach them
  assign out_valid  = slot_full_q && (credit_q != '0);
  assign out_data   = slot_data_q;
  assign out_id     = slot_id_q;
  assign credit_err = credit_err_q;

  assign out_hs   = out_valid && out_ready;
  assign loadable = !slot_full_q || out_hs;
  assign req_hs   = loadable && any_req && !rst;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping
  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!any_req && req_valid[IDW'((int'(rr_ptr_q) + k) % NREQ)]) begin
        any_req = 1'b1;
        winner  = IDW'((int'(rr_ptr_q) + k) % NREQ);
      end
    end
  end

  // Grant is one-hot on the winner, only when the slot can take it
  always_comb begin
    req_ready = '0;
    if (req_hs) begin
      req_ready[winner] = 1'b1;
    end
  end

  // Slot load/drain and pointer advance
  always_comb begin
    slot_full_d = slot_full_q;
    slot_data_d = slot_data_q;
    slot_id_d   = slot_id_q;
    rr_ptr_d    = rr_ptr_q;
    if (req_hs) begin
      slot_full_d = 1'b1;
      slot_data_d = req_data[int'(winner)*DW +: DW];
      slot_id_d   = winner;
      rr_ptr_d    = IDW'((int'(winner) + 1) % NREQ);
    end else if (out_hs) begin
      slot_full_d = 1'b0;
    end
  end

  // Credit accounting: simultaneous spend and return cancel out
  always_comb begin
    credit_d     = credit_q;
    credit_err_d = credit_err_q;
    if (out_hs && !credit_ret) begin
      credit_d = credit_q - 1'b1;
    end else if (credit_ret && !out_hs) begin
      if (credit_q == CRED_MAX) begin
        credit_err_d = 1'b1;
      end else begin
        credit_d = credit_q + 1'b1;
      end
    end
  end

  // Slot registers; reset discards any in-flight item
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_full_q <= 1'b0;
      slot_data_q <= '0;
      slot_id_q   <= '0;
    end else begin
      slot_full_q <= slot_full_d;
      slot_data_q <= slot_data_d;
      slot_id_q   <= slot_id_d;
    end
  end

  // Round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Credit counter and sticky overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_q     <= CRED_MAX;
      credit_err_q <= 1'b0;
    end else begin
      credit_q     <= credit_d;
      credit_err_q <= credit_err_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed and randomized checks of wb_arbiter against a queue-based model
module tb_wb_arbiter;

  localparam int NREQ    = 4;
  localparam int DW      = 32;
  localparam int IDW     = 2;
  localparam int CREDITS = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*DW-1:0]  req_data;
  logic                out_valid;
  logic                out_ready;
  logic [DW-1:0]       out_data;
  logic [IDW-1:0]      out_id;
  logic                credit_ret;
  logic                credit_err;

  int checks = 0;
  int errors = 0;

  // Model: the slot is a queue of at most one item, credits are a plain count
  logic [DW-1:0] m_data_q[$];
  int            m_id_q[$];
  int            m_ptr;
  int            m_cred;
  bit            m_err;
  int            m_grant;
  bit            m_out_hs;

  wb_arbiter #(.NREQ(NREQ), .DW(DW), .IDW(IDW), .CREDITS(CREDITS)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_id     (out_id),
    .credit_ret (credit_ret),
    .credit_err (credit_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_data_q.delete();
    m_id_q.delete();
    m_ptr    = 0;
    m_cred   = CREDITS;
    m_err    = 1'b0;
    m_grant  = -1;
    m_out_hs = 1'b0;
  endtask

  // Drive inputs just after a falling edge, let them settle, compare against the model
  task automatic apply(input logic [NREQ-1:0] v, input bit ordy, input bit cret);
    bit              full;
    bit              exp_ov;
    bit              loadable;
    int              win;
    logic [NREQ-1:0] exp_rr;
    req_valid  = v;
    out_ready  = ordy;
    credit_ret = cret;
    #1;
    full     = (m_data_q.size() != 0);
    exp_ov   = !rst && full && (m_cred > 0);
    m_out_hs = exp_ov && ordy;
    loadable = !full || m_out_hs;
    win = -1;
    for (int k = 0; k < NREQ; k++) begin
      if (win < 0 && v[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
    end
    m_grant = (!rst && loadable) ? win : -1;
    exp_rr  = '0;
    if (m_grant >= 0) exp_rr[m_grant] = 1'b1;
    check("m_req_ready", req_ready, exp_rr);
    check("m_out_valid", out_valid, exp_ov);
    check("m_credit_err", credit_err, m_err);
    if (!rst && full) begin
      check("m_out_data", out_data, m_data_q[0]);
      check("m_out_id", out_id, m_id_q[0]);
    end
  endtask

  // Advance the model across the rising edge and move to the next falling edge
  task automatic clk_edge();
    if (rst) begin
      model_reset();
    end else begin
      if (m_out_hs) begin
        m_data_q.delete(0);
        m_id_q.delete(0);
      end
      if (m_grant >= 0) begin
        m_data_q.push_back(req_data[m_grant*DW +: DW]);
        m_id_q.push_back(m_grant);
        m_ptr = (m_grant + 1) % NREQ;
      end
      if (m_out_hs && !credit_ret) begin
        m_cred--;
      end else if (credit_ret && !m_out_hs) begin
        if (m_cred == CREDITS) m_err = 1'b1;
        else m_cred++;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    req_valid  = '0;
    out_ready  = 1'b0;
    credit_ret = 1'b0;
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic fill_data(input logic [31:0] base);
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = base + 32'(i);
  endtask

  initial begin
    int          order[5];
    logic [NREQ-1:0] v;
    bit          cret;
    int          outstanding;
    order = '{0, 1, 2, 3, 0};

    rst = 1'b1;
    req_valid = '0; req_data = '0; out_ready = 1'b0; credit_ret = 1'b0;
    model_reset();
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_id", out_id, 0);
    check("rst_credit_err", credit_err, 0);
    check("rst_credit_cnt", dut.credit_q, CREDITS);
    req_valid = 4'b1111;
    #1;
    check("rst_req_ready", req_ready, 0);
    @(negedge clk);
    rst = 1'b0;

    // Single requester, one-cycle latency
    req_data[1*DW +: DW] = 32'hA5A5_0001;
    apply(4'b0010, 1'b1, 1'b0);
    check("single_ready", req_ready, 4'b0010);
    clk_edge();
    apply(4'b0000, 1'b1, 1'b0);
    check("single_valid", out_valid, 1);
    check("single_data", out_data, 32'hA5A5_0001);
    check("single_id", out_id, 1);
    clk_edge();

    // Round-robin with credits echoed every handshake
    do_reset();
    fill_data(32'h3400_0000);
    for (int c = 0; c < 5; c++) begin
      cret = (m_data_q.size() != 0) && (m_cred > 0);
      apply(4'b1111, 1'b1, cret);
      check("rr_grant", req_ready, 4'b0001 << order[c]);
      if (c > 0) begin
        check("rr_out_valid", out_valid, 1);
        check("rr_out_id", out_id, order[c-1]);
      end
      clk_edge();
    end

    // Credit stall and release
    do_reset();
    fill_data(32'h3500_0000);
    apply(4'b0111, 1'b1, 1'b0); clk_edge();
    apply(4'b0110, 1'b1, 1'b0); clk_edge();
    apply(4'b0100, 1'b1, 1'b0); clk_edge();
    apply(4'b0000, 1'b1, 1'b0);
    check("stall_valid", out_valid, 0);
    check("stall_id", out_id, 2);
    clk_edge();
    apply(4'b0000, 1'b1, 1'b1);
    check("stall_still", out_valid, 0);
    clk_edge();
    apply(4'b0000, 1'b1, 1'b0);
    check("release_valid", out_valid, 1);
    check("release_id", out_id, 2);
    check("release_data", out_data, 32'h3500_0002);
    clk_edge();

    // Back-pressure holds slot and blocks grants
    do_reset();
    fill_data(32'h3600_0000);
    apply(4'b0001, 1'b0, 1'b0); clk_edge();
    for (int c = 0; c < 5; c++) begin
      apply(4'b1111, 1'b0, 1'b0);
      check("bp_ready", req_ready, 0);
      check("bp_data", out_data, 32'h3600_0000);
      check("bp_id", out_id, 0);
      clk_edge();
    end
    apply(4'b1111, 1'b1, 1'b0);
    check("bp_resume", req_ready, 4'b0010);
    clk_edge();

    // Credit overflow is sticky and saturates
    do_reset();
    apply(4'b0000, 1'b0, 1'b1); clk_edge();
    for (int c = 0; c < 3; c++) begin
      apply(4'b0000, 1'b0, 1'b0);
      check("ovf_err", credit_err, 1);
      check("ovf_cnt", dut.credit_q, CREDITS);
      clk_edge();
    end

    // Asynchronous reset mid-operation
    do_reset();
    fill_data(32'h3800_0000);
    apply(4'b0001, 1'b0, 1'b0); clk_edge();
    apply(4'b0001, 1'b0, 1'b0);
    check("pre_rst_valid", out_valid, 1);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    check("async_valid", out_valid, 0);
    check("async_data", out_data, 0);
    check("async_ready", req_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    apply(4'b1000, 1'b1, 1'b0);
    check("post_rst_grant", req_ready, 4'b1000);
    clk_edge();
    apply(4'b0000, 1'b1, 1'b0);
    check("post_rst_id", out_id, 3);
    clk_edge();

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (c == 300) do_reset();
      for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = $urandom;
      v = NREQ'($urandom);
      outstanding = CREDITS - m_cred;
      if (outstanding > 0) cret = ($urandom_range(0, 1) == 1);
      else cret = ($urandom_range(0, 99) == 0);
      apply(v, ($urandom_range(0, 3) != 0), cret);
      clk_edge();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
